// File: rtl/mod_counter_bcd.sv
// mod_counter_bcd
//   Modulo-(limit+1) up/down counter with synchronous load, registered
//   carry/borrow wrap pulses and combinational BCD digits of the count.
//   Cascade stages by feeding a stage's carry (up) or borrow (down) into
//   the next stage's en; all stages share clk.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset (count <= RST_VAL)
//   en       : count enable, one step per cycle
//   up_dn    : 1 = count up, 0 = count down
//   limit    : terminal count, may change at any time
//   load     : synchronous load strobe (beats en)
//   load_val : value to load, clamped to limit
//   count    : registered count
//   carry    : one-cycle pulse alongside the count that wrapped limit -> 0
//   borrow   : one-cycle pulse alongside the count that wrapped 0 -> limit
//   d2/d1/d0 : BCD hundreds/tens/ones of count
module mod_counter_bcd #(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic [3:0]       d2,
  output logic [3:0]       d1,
  output logic [3:0]       d0
);

  logic [9:0] cnt10;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= WIDTH'(RST_VAL);
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else if (load) begin
      count  <= (load_val > limit) ? limit : load_val;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else if (en) begin
      if (up_dn) begin
        // >= rather than == so a count stranded above a lowered limit wraps
        if (count >= limit) begin
          count <= '0;
          carry <= 1'b1;
        end else begin
          count <= count + 1'b1;
          carry <= 1'b0;
        end
        borrow <= 1'b0;
      end else begin
        if (count == '0) begin
          count  <= limit;
          borrow <= 1'b1;
        end else if (count > limit) begin
          // limit was lowered under us: snap to it without a borrow
          count  <= limit;
          borrow <= 1'b0;
        end else begin
          count  <= count - 1'b1;
          borrow <= 1'b0;
        end
        carry <= 1'b0;
      end
    end else begin
      carry  <= 1'b0;
      borrow <= 1'b0;
    end
  end

  // Digits straight from the registered count; d2 can read 10 for
  // counts 1000..1023 when WIDTH is 10.
  always_comb begin
    cnt10 = 10'(count);
    d2    = 4'(cnt10 / 10'd100);
    d1    = 4'((cnt10 / 10'd10) % 10'd10);
    d0    = 4'(cnt10 % 10'd10);
  end

endmodule

// File: tb/tb_mod_counter_bcd.sv
module tb_mod_counter_bcd;

  logic       clk = 1'b0;
  logic       rst;
  // narrow instance (WIDTH=6, RST_VAL=0)
  logic       a_en, a_up, a_load;
  logic [5:0] a_limit, a_lv, a_count;
  logic       a_carry, a_borrow;
  logic [3:0] a_d2, a_d1, a_d0;
  // wide instance (WIDTH=10, RST_VAL=7)
  logic       b_en, b_up, b_load;
  logic [9:0] b_limit, b_lv, b_count;
  logic       b_carry, b_borrow;
  logic [3:0] b_d2, b_d1, b_d0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       sel;
    logic [9:0] cnt;
    logic       c;
    logic       b;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  mod_counter_bcd #(.WIDTH(6), .RST_VAL(0)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .up_dn(a_up), .limit(a_limit),
    .load(a_load), .load_val(a_lv), .count(a_count), .carry(a_carry),
    .borrow(a_borrow), .d2(a_d2), .d1(a_d1), .d0(a_d0)
  );

  mod_counter_bcd #(.WIDTH(10), .RST_VAL(7)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .up_dn(b_up), .limit(b_limit),
    .load(b_load), .load_val(b_lv), .count(b_count), .carry(b_carry),
    .borrow(b_borrow), .d2(b_d2), .d1(b_d1), .d0(b_d0)
  );

  // Monitor: one expected entry per clock, compared on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      string      nm;
      logic [9:0] act_cnt;
      logic       act_c, act_b;
      logic [3:0] act_d2, act_d1, act_d0;
      logic [3:0] e_d2, e_d1, e_d0;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.sel) begin
        act_cnt = b_count; act_c = b_carry; act_b = b_borrow;
        act_d2 = b_d2; act_d1 = b_d1; act_d0 = b_d0;
      end else begin
        act_cnt = {4'b0, a_count}; act_c = a_carry; act_b = a_borrow;
        act_d2 = a_d2; act_d1 = a_d1; act_d0 = a_d0;
      end
      e_d2 = 4'(e.cnt / 10'd100);
      e_d1 = 4'((e.cnt / 10'd10) % 10'd10);
      e_d0 = 4'(e.cnt % 10'd10);
      checks++;
      if (act_cnt !== e.cnt || act_c !== e.c || act_b !== e.b ||
          act_d2 !== e_d2 || act_d1 !== e_d1 || act_d0 !== e_d0) begin
        errors++;
        $display("FAIL %s: got count=%0d carry=%b borrow=%b d=%0d%0d%0d, want count=%0d carry=%b borrow=%b d=%0d%0d%0d",
                 nm, act_cnt, act_c, act_b, act_d2, act_d1, act_d0,
                 e.cnt, e.c, e.b, e_d2, e_d1, e_d0);
      end
    end
  end

  // Drive one cycle of stimulus (after the monitor's edge) and queue the
  // expected post-edge state of the selected instance; the other idles.
  task automatic step(input logic r, input logic ld, input logic e,
                      input logic ud, input logic [9:0] lim,
                      input logic [9:0] lv, input logic sel,
                      input logic [9:0] ecnt, input logic ec,
                      input logic eb, input string nm);
    exp_t x;
    @(negedge clk);
    #1;
    rst = r;
    if (sel) begin
      b_load = ld; b_en = e; b_up = ud; b_limit = lim; b_lv = lv;
      a_load = 1'b0; a_en = 1'b0;
    end else begin
      a_load = ld; a_en = e; a_up = ud; a_limit = lim[5:0]; a_lv = lv[5:0];
      b_load = 1'b0; b_en = 1'b0;
    end
    x.sel = sel; x.cnt = ecnt; x.c = ec; x.b = eb;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, want done", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_en = 0; a_up = 1; a_load = 0; a_limit = 6'd59; a_lv = '0;
    b_en = 0; b_up = 1; b_load = 0; b_limit = 10'd999; b_lv = '0;

    // reset and hold
    step(1, 0, 0, 1, 59, 0, 0, 0, 0, 0, "reset1");
    step(1, 1, 1, 1, 59, 9, 0, 0, 0, 0, "reset2_beats_load");
    step(0, 0, 0, 1, 59, 0, 1, 7, 0, 0, "wide_rst_val");
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 1, 59, 0, 0, 0, 0, 0, "hold");

    // up count to 59 and wrap, then one more step
    for (int i = 1; i <= 61; i++)
      step(0, 0, 1, 1, 59, 0, 0, 10'(i % 60), (i == 60), 0, "up_wrap");
    step(0, 0, 0, 1, 59, 0, 0, 1, 0, 0, "hold_after_wrap");

    // down wrap 0 -> 23
    step(0, 1, 0, 0, 23, 0, 0, 0, 0, 0, "load_zero");
    step(0, 0, 1, 0, 23, 0, 0, 23, 0, 1, "down_wrap");
    step(0, 0, 1, 0, 23, 0, 0, 22, 0, 0, "down_after_wrap");

    // load clamp, load beats en, rst beats load
    step(0, 1, 1, 1, 40, 55, 0, 40, 0, 0, "load_clamp");
    step(0, 1, 0, 1, 40, 12, 0, 12, 0, 0, "load_plain");
    step(1, 1, 1, 1, 40, 33, 0, 0, 0, 0, "rst_beats_load");

    // limit lowered below count
    step(0, 1, 0, 1, 63, 50, 0, 50, 0, 0, "load50_up");
    step(0, 0, 1, 1, 30, 0, 0, 0, 1, 0, "lowered_up");
    step(0, 1, 0, 1, 63, 50, 0, 50, 0, 0, "load50_dn");
    step(0, 0, 1, 0, 30, 0, 0, 30, 0, 0, "lowered_dn");
    step(0, 0, 1, 0, 30, 0, 0, 29, 0, 0, "dn_after_lower");

    // limit = 0: every enabled step wraps
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, "limit0_up");
    for (int i = 0; i < 2; i++)
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, "limit0_dn");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "limit0_idle");

    // wide instance around 999
    step(0, 1, 0, 1, 999, 998, 1, 998, 0, 0, "wide_load998");
    step(0, 0, 1, 1, 999, 0, 1, 999, 0, 0, "wide_999");
    step(0, 0, 1, 1, 999, 0, 1, 0, 1, 0, "wide_wrap");
    step(0, 0, 1, 1, 999, 0, 1, 1, 0, 0, "wide_after_wrap");
    step(0, 1, 0, 1, 1023, 1023, 1, 1023, 0, 0, "wide_load1023");

    // let the monitor drain, bounded
    for (int i = 0; i < 4 && exp_q.size() > 0; i++)
      @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_counter_bcd.md
Name: mod_counter_bcd

Overview:
- Parametrised modulo-(limit+1) up/down counter with synchronous load, a registered carry/borrow pulse and BCD digit outputs.
- Generalises the fixed minute counter for use in the clock/timer datapath: seconds, minutes, hours, countdown timers.
- Stages cascade by driving the next stage's `en` from this stage's `carry` (counting up) or `borrow` (counting down).
- All stages share a single clock.

Parameters:
- WIDTH, 6, bit width of `count`, `limit` and `load_val`; legal range 1..10.
- RST_VAL, 0, value loaded into `count` on reset; must be <= the runtime `limit`.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; advances the count by one step per cycle while high.
- up_dn  in  1  direction: 1 = count up, 0 = count down.
- limit  in  WIDTH  terminal (maximum) count value; may change at any time.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count (registered).
- carry  out  1  one-cycle pulse after an up-wrap from `limit` to 0 (registered).
- borrow  out  1  one-cycle pulse after a down-wrap from 0 to `limit` (registered).
- d2  out  4  BCD hundreds digit of `count`.
- d1  out  4  BCD tens digit of `count`.
- d0  out  4  BCD ones digit of `count`.

Behaviour:
- One clock domain; reset is synchronous and active-high. Clock port is `clk`, reset port is `rst`.
- Reset: count=RST_VAL, carry=0, borrow=0. `rst` held high wins over every other input.
- Priority per edge: rst > load > en. en=0 and load=0: count holds; carry and borrow both 0.
- load=1: count <= min(load_val, limit); carry=0, borrow=0; `en` and `up_dn` are ignored that cycle.
- en=1, up_dn=1:
  - count < limit: count+1, carry=0.
  - count >= limit: count <= 0, carry=1.
- en=1, up_dn=0:
  - 0 < count <= limit: count-1, borrow=0.
  - count == 0: count <= limit, borrow=1.
  - count > limit (limit lowered at runtime): count <= limit, borrow=0.
- Pulse timing: carry/borrow are registered and high for exactly the one cycle in which `count` first shows the wrapped value.
  - Continuous enabled wrapping (e.g. limit=0) produces carry held high on consecutive cycles: one pulse per wrap.
  - carry and borrow are never high in the same cycle.
- limit=0: count stays 0. Every enabled up step asserts carry; every enabled down step asserts borrow.
- Arithmetic is unsigned; internal +1/-1 never overflows WIDTH because of the wrap rules above.
- BCD outputs are combinational from registered `count`: d2 = count/100, d1 = (count/10)%10, d0 = count%10. Upper digits read 0 when WIDTH is small. Zero latency relative to `count`.
- Direction change takes effect on the same edge; there is no pipeline.
- Reset mid-count or mid-pulse: the next edge yields RST_VAL with carry/borrow cleared.

Test Plan:
- Reset/hold: rst=1 for 2 cycles, then en=0 for 5 cycles -> count=0, carry=0, borrow=0, d1=d0=0 throughout.
- Up-wrap: limit=59, en=1, up_dn=1 for 61 cycles from 0 -> count 0..59, then 0 with carry=1 for exactly that cycle; d1=5, d0=9 at count 59.
- Down-wrap: limit=23, count=0, up_dn=0, en=1 -> count=23, borrow=1 for one cycle; next cycle count=22, borrow=0.
- Load clamp and priority: limit=40, load=1, load_val=55, en=1 -> count=40, no carry. Then load=1 with rst=1 -> count=0.
- Limit lowered: count=50, limit changed to 30, en=1, up_dn=1 -> count=0, carry=1. Repeat with up_dn=0 -> count=30, borrow=0.
- Wide/limit=0: WIDTH=10, limit=999, load 998, step up twice -> 999 (d2=9, d1=9, d0=9) then 0 with carry=1. Separately, limit=0 with en=1 for 3 cycles -> carry high on all 3 cycles.
